// File: rtl/wave_ram_arbiter.sv
// Single-port sample RAM arbiter: display reads always win,
// capture writes queue in a small FIFO and drain on idle cycles.
module wave_ram_arbiter #(
   parameter int ADDR_W       = 10,
   parameter int DATA_W       = 8,
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 800
) (
   input  logic                          sys_clk,
   input  logic                          sys_rst,
   input  logic                          disp_rd_en,
   input  logic [ADDR_W-1:0]             disp_rd_addr,
   output logic [DATA_W-1:0]             disp_rd_data,
   output logic                          disp_rd_valid,
   input  logic                          cap_wr_valid,
   output logic                          cap_wr_ready,
   input  logic [ADDR_W-1:0]             cap_wr_addr,
   input  logic [DATA_W-1:0]             cap_wr_data,
   output logic                          ram_en,
   output logic                          ram_we,
   output logic [ADDR_W-1:0]             ram_addr,
   output logic [DATA_W-1:0]             ram_wdata,
   input  logic [DATA_W-1:0]             ram_rdata,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          starved,
   input  logic                          starve_clr
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

   localparam logic [PTR_W-1:0] PTR_ONE = 1;
   localparam logic [LVL_W-1:0] LVL_ONE = 1;
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE = 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
   logic [DATA_W-1:0] data_mem [FIFO_DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic             rd_valid_q, rd_valid_d;
   logic             starved_q, starved_d;

   logic empty, full, push, pop, rd_go;

   assign empty = (level_q == '0);
   assign full  = (level_q == LVL_FULL);
   assign rd_go = disp_rd_en && !sys_rst;
   assign pop   = !sys_rst && !disp_rd_en && !empty;

   assign cap_wr_ready = !full && !sys_rst;
   assign push         = cap_wr_valid && cap_wr_ready;

   // Port grant: reads first, then the FIFO head.
   always_comb begin
      ram_en    = rd_go || pop;
      ram_we    = pop;
      ram_addr  = '0;
      ram_wdata = '0;
      if (rd_go) begin
         ram_addr = disp_rd_addr;
      end else if (pop) begin
         ram_addr  = addr_mem[rd_ptr_q];
         ram_wdata = data_mem[rd_ptr_q];
      end
   end

   always_comb begin
      wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      level_d    = level_q;
      rd_valid_d = rd_go;
      if (push && !pop) level_d = level_q + LVL_ONE;
      else if (pop && !push) level_d = level_q - LVL_ONE;
   end

   // Stall counter only runs while a write is held off by a read.
   always_comb begin
      stall_d = stall_q;
      if (pop || empty) stall_d = '0;
      else if (disp_rd_en && stall_q != CNT_MAX) stall_d = stall_q + CNT_ONE;
      starved_d = starved_q;
      if (stall_d == CNT_MAX) starved_d = 1'b1;
      else if (starve_clr) starved_d = 1'b0;
   end

   always_ff @(posedge sys_clk) begin
      if (push) begin
         addr_mem[wr_ptr_q] <= cap_wr_addr;
         data_mem[wr_ptr_q] <= cap_wr_data;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         stall_q    <= '0;
         rd_valid_q <= 1'b0;
         starved_q  <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         stall_q    <= stall_d;
         rd_valid_q <= rd_valid_d;
         starved_q  <= starved_d;
      end
   end

   assign disp_rd_data  = ram_rdata;
   assign disp_rd_valid = rd_valid_q;
   assign fifo_level    = level_q;
   assign starved       = starved_q;

endmodule

// File: doc/wave_ram_arbiter.md
Name: wave_ram_arbiter

Overview:
- Shares one single-port waveform sample RAM between two requesters: the VGA display reader (pixel-rate column reads) and the capture writer (acquisition samples).
- Display reads always win, so the pixel stream never stalls. Capture writes are buffered in a small FIFO and drained on cycles the display leaves free.
- Sits between the capture block, the VGA pixel path and the sample RAM (1-cycle synchronous read latency).

Parameters:
- ADDR_W, 10, sample RAM address width (640 columns used).
- DATA_W, 8, sample width.
- FIFO_DEPTH, 4, write-buffer entries; must be a power of 2, at least 2.
- STARVE_LIMIT, 800, consecutive blocked-write cycles that set starved (one 800-clock line).

Ports:
- sys_clk  in  1  system clock; all logic on the rising edge.
- sys_rst  in  1  synchronous reset, active-high.
- disp_rd_en  in  1  display read request this cycle.
- disp_rd_addr  in  ADDR_W  display read address.
- disp_rd_data  out  DATA_W  read data; equals ram_rdata.
- disp_rd_valid  out  1  disp_rd_data valid.
- cap_wr_valid  in  1  capture write offered.
- cap_wr_ready  out  1  FIFO can accept.
- cap_wr_addr  in  ADDR_W  capture write address.
- cap_wr_data  in  DATA_W  capture write data.
- ram_en  out  1  RAM access enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, 1 cycle after a read.
- fifo_level  out  clog2(FIFO_DEPTH)+1  entries currently buffered.
- starved  out  1  sticky; writes were blocked too long.
- starve_clr  in  1  clears starved.

Behaviour:
- Reset: while sys_rst=1, and on the first cycle after it deasserts:
  - FIFO empty; fifo_level=0.
  - ram_en=0, ram_we=0; disp_rd_valid=0; starved=0; stall counter=0.
  - cap_wr_ready=0 while sys_rst=1.
  - Reset mid-operation discards all buffered writes; nothing is written to RAM.
- Port grant (combinational, each cycle):
  - disp_rd_en=1: ram_en=1, ram_we=0, ram_addr=disp_rd_addr.
  - else if FIFO non-empty: ram_en=1, ram_we=1, ram_addr/ram_wdata = FIFO head; head popped at this edge.
  - else: ram_en=0, ram_we=0; ram_addr/ram_wdata are don't-care (drive 0).
- Read latency: disp_rd_valid is a register, set exactly 1 cycle after each cycle with disp_rd_en=1. Back-to-back reads give back-to-back valid.
- No write-to-read forwarding: a read of an address still in the FIFO returns the old RAM contents.
- FIFO:
  - cap_wr_ready = !full and !sys_rst.
  - Push on cap_wr_valid && cap_wr_ready.
  - No same-cycle bypass: a push into an empty FIFO reaches RAM no earlier than the next cycle.
  - Push and pop in the same cycle: level unchanged.
  - When full, ready=0, so no push occurs even if a pop happens that cycle.
  - Entries write to RAM in push order; pointers wrap modulo FIFO_DEPTH.
- Starvation:
  - Stall counter increments on each cycle with FIFO non-empty and disp_rd_en=1.
  - Counter resets to 0 on any cycle a pop occurs or the FIFO is empty.
  - Counter saturates at STARVE_LIMIT.
  - When it reaches STARVE_LIMIT, starved sets; it stays set until starve_clr=1.
  - Set and starve_clr in the same cycle: set wins.
  - starve_clr does not clear the counter.

Test Plan:
- Reset release, idle: no requests for 10 cycles -> ram_en=0, cap_wr_ready=1, fifo_level=0, disp_rd_valid=0.
- Single write: push addr=5 data=0xA3 into empty FIFO, disp_rd_en=0 -> next cycle ram_en=1, ram_we=1, ram_addr=5, ram_wdata=0xA3; fifo_level back to 0.
- Collision: disp_rd_en=1 for 3 cycles while 2 writes are buffered -> RAM sees only the 3 reads; disp_rd_valid high for cycles 2-4; both writes land in the 2 cycles after disp_rd_en drops, in push order.
- Full: 5 pushes with disp_rd_en held 1 -> cap_wr_ready=0 after the 4th push; the 5th is held off; fifo_level=4; the 5th is accepted the cycle after the first pop.
- Starve: 1 entry buffered, disp_rd_en held 1 for 800 cycles -> starved=1 at cycle 800; then starve_clr pulse with disp_rd_en=0 -> pop occurs, starved=0.
- Reset mid-operation: sys_rst pulsed with 3 entries buffered -> fifo_level=0, no RAM write issued afterwards, starved=0.
